// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

   localparam int DROP_CNT_W = 16;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

   // Selector width for n channels; a 1-bit floor keeps n=2 (and degenerate n) legal.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slot: holds a word until its consumer takes it.
module demux_slot #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             can_take
);

   // A full slot can still accept when its consumer drains it on the same edge.
   assign can_take = !valid || rd_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (wr_en) begin
         valid <= 1'b1;
         data  <= wr_data;
      end else if (rd_ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_stream_1n.sv
// Registered 1-to-N stream demux with per-channel one-entry buffers, broadcast
// and out-of-range selector dropping with a saturating drop counter.
module demux_stream_1n
   import demux_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SEL_W = sel_width(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_bcast,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [N*WIDTH-1:0]    out_data,
   output logic [N-1:0]          out_valid,
   input  logic [N-1:0]          out_ready,
   output logic                  drop_pulse,
   output logic [DROP_CNT_W-1:0] drop_count
);

   // Handshake: a word moves on any rising edge where valid && ready are both 1.
   // in_ready never depends on in_valid; out_valid never depends on out_ready.

   localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

   logic [N-1:0] can_take;
   logic [N-1:0] sel_onehot;
   logic [N-1:0] wr_en;
   logic         in_range;
   logic         sel_take;
   logic         accept;
   logic         drop;

   assign in_range = ({1'b0, in_sel} < N_EXT);

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (in_sel == SEL_W'(i)) begin
            sel_onehot[i] = 1'b1;
         end
      end
   end

   assign sel_take = |(sel_onehot & can_take);

   // Broadcast waits for every slot so it is never partially written;
   // out-of-range words are always sunk.
   always_comb begin
      in_ready = 1'b1;
      if (in_bcast) begin
         in_ready = &can_take;
      end else if (in_range) begin
         in_ready = sel_take;
      end
   end

   assign accept = in_valid && in_ready;
   assign wr_en  = {N{accept}} & ({N{in_bcast}} | sel_onehot);
   assign drop   = accept && !in_bcast && !in_range;

   for (genvar g = 0; g < N; g++) begin : g_slot
      demux_slot #(
         .WIDTH(WIDTH)
      ) u_slot (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en[g]),
         .wr_data (in_data),
         .rd_ready(out_ready[g]),
         .valid   (out_valid[g]),
         .data    (out_data[g*WIDTH +: WIDTH]),
         .can_take(can_take[g])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_pulse <= 1'b0;
         drop_count <= '0;
      end else begin
         drop_pulse <= drop;
         if (drop && (drop_count != DROP_CNT_MAX)) begin
            drop_count <= drop_count + DROP_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_demux_stream_1n.sv
// Bench for demux_stream_1n: N=4 main instance checked against a queue model,
// plus an N=3 instance for out-of-range selector dropping.
module tb_demux_stream_1n;

   localparam int W = 16;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [W-1:0]   in_data;
   logic [1:0]     in_sel;
   logic           in_bcast;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_valid;
   logic [N-1:0]   out_ready;
   logic           drop_pulse;
   logic [15:0]    drop_count;

   logic [W-1:0]   d3_data;
   logic [1:0]     d3_sel;
   logic           d3_bcast;
   logic           d3_valid;
   logic           d3_ready;
   logic [3*W-1:0] d3_out_data;
   logic [2:0]     d3_out_valid;
   logic [2:0]     d3_out_ready;
   logic           d3_drop_pulse;
   logic [15:0]    d3_drop_count;

   demux_stream_1n #(.WIDTH(W), .N(N)) u_dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .drop_pulse(drop_pulse), .drop_count(drop_count)
   );

   demux_stream_1n #(.WIDTH(W), .N(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .in_data(d3_data), .in_sel(d3_sel), .in_bcast(d3_bcast),
      .in_valid(d3_valid), .in_ready(d3_ready),
      .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
      .drop_pulse(d3_drop_pulse), .drop_count(d3_drop_count)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: each channel is a queue of words the consumer has yet to take.
   logic [W-1:0] exp_q[N][$];

   function automatic logic [N-1:0] model_valid();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = (exp_q[i].size() != 0);
      return v;
   endfunction

   function automatic logic model_ready(input logic [1:0] s, input logic b, input logic [N-1:0] r);
      logic ok;
      ok = 1'b1;
      if (b) begin
         for (int i = 0; i < N; i++)
            if (exp_q[i].size() != 0 && !r[i]) ok = 1'b0;
      end else begin
         ok = (exp_q[int'(s)].size() == 0) || r[int'(s)];
      end
      return ok;
   endfunction

   task automatic drive(input logic [W-1:0] d, input logic [1:0] s, input logic b,
                        input logic v, input logic [N-1:0] r);
      in_data   = d;
      in_sel    = s;
      in_bcast  = b;
      in_valid  = v;
      out_ready = r;
   endtask

   // Advance the model by one edge, then step to the next falling edge.
   task automatic tick();
      logic acc;
      acc = in_valid && model_ready(in_sel, in_bcast, out_ready);
      for (int i = 0; i < N; i++)
         if (exp_q[i].size() != 0 && out_ready[i]) void'(exp_q[i].pop_front());
      if (acc)
         for (int i = 0; i < N; i++)
            if (in_bcast || int'(in_sel) == i) exp_q[i].push_back(in_data);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      total++;
      if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
      total++;
      if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
      total++;
      if (drop_pulse !== 1'b0 || drop_count !== 16'd0) begin
         bad++; $display("FAIL reset_drop got=%b/%0d exp=0/0", drop_pulse, drop_count);
      end
      total++;
      if (d3_out_valid !== 3'b000 || d3_drop_count !== 16'd0) begin
         bad++; $display("FAIL reset_dut3 got=%b/%0d exp=000/0", d3_out_valid, d3_drop_count);
      end
      reset = 1'b0;
      @(negedge clk);
      drive(16'h1111, 2'd1, 1'b0, 1'b1, 4'b0000);
      tick();
      drive(16'h3333, 2'd3, 1'b0, 1'b1, 4'b0000);
      tick();
      total++;
      if (out_valid !== 4'b1010) begin bad++; $display("FAIL fill_1_3 got=%b exp=1010", out_valid); end
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b0000);
      #2 reset = 1'b1;
      #1;
      total++;
      if (out_valid !== 4'b0000) begin bad++; $display("FAIL midreset_valid got=%b exp=0000", out_valid); end
      total++;
      if (drop_count !== 16'd0 || out_data !== '0) begin
         bad++; $display("FAIL midreset_state got=%0d/%h exp=0/0", drop_count, out_data);
      end
      for (int i = 0; i < N; i++) exp_q[i].delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_routing();
      drive(16'hA5A5, 2'd2, 1'b0, 1'b1, 4'b1111);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready got=%b exp=1", in_ready); end
      tick();
      total++;
      if (out_valid !== 4'b0100) begin bad++; $display("FAIL route_valid got=%b exp=0100", out_valid); end
      total++;
      if (out_data[47:32] !== 16'hA5A5) begin bad++; $display("FAIL route_data got=%h exp=a5a5", out_data[47:32]); end
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
      tick();
      total++;
      if (out_valid !== 4'b0000) begin bad++; $display("FAIL route_clear got=%b exp=0000", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] w1, w2;
      w1 = W'($urandom);
      w2 = W'($urandom);
      drive(w1, 2'd0, 1'b0, 1'b1, 4'b1110);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
      tick();
      drive(w2, 2'd0, 1'b0, 1'b1, 4'b1110);
      for (int k = 0; k < 2; k++) begin
         #1;
         total++;
         if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready); end
         tick();
         total++;
         if (out_valid !== 4'b0001 || out_data[15:0] !== w1) begin
            bad++; $display("FAIL bp_hold got=%b/%h exp=0001/%h", out_valid, out_data[15:0], w1);
         end
      end
      out_ready = 4'b1111;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      tick();
      total++;
      if (out_valid !== 4'b0001 || out_data[15:0] !== w2) begin
         bad++; $display("FAIL bp_second got=%b/%h exp=0001/%h", out_valid, out_data[15:0], w2);
      end
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
      tick();
      total++;
      if (out_valid !== 4'b0000) begin bad++; $display("FAIL bp_drain got=%b exp=0000", out_valid); end
   endtask

   task automatic test_broadcast();
      logic [W-1:0] x;
      x = W'($urandom);
      drive(x, 2'd2, 1'b0, 1'b1, 4'b1011);
      tick();
      drive(16'h1234, 2'd0, 1'b1, 1'b1, 4'b1011);
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_blocked got=%b exp=0", in_ready); end
      tick();
      total++;
      if (out_valid !== 4'b0100 || out_data[47:32] !== x) begin
         bad++; $display("FAIL bc_no_partial got=%b/%h exp=0100/%h", out_valid, out_data[47:32], x);
      end
      out_ready = 4'b1111;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_release got=%b exp=1", in_ready); end
      tick();
      total++;
      if (out_valid !== 4'b1111) begin bad++; $display("FAIL bc_valid got=%b exp=1111", out_valid); end
      for (int i = 0; i < N; i++) begin
         total++;
         if (out_data[i*W +: W] !== 16'h1234) begin
            bad++; $display("FAIL bc_data ch%0d got=%h exp=1234", i, out_data[i*W +: W]);
         end
      end
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
      tick();
   endtask

   task automatic test_out_of_range();
      logic [W-1:0] y;
      y = W'($urandom);
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
      d3_data = y; d3_sel = 2'd1; d3_bcast = 1'b0; d3_valid = 1'b1; d3_out_ready = 3'b000;
      tick();
      for (int k = 1; k <= 3; k++) begin
         d3_data = W'($urandom); d3_sel = 2'd3; d3_valid = 1'b1;
         #1;
         total++;
         if (d3_ready !== 1'b1) begin bad++; $display("FAIL oor_ready #%0d got=%b exp=1", k, d3_ready); end
         tick();
         total++;
         if (d3_drop_pulse !== 1'b1 || d3_drop_count !== 16'(k)) begin
            bad++; $display("FAIL oor_drop #%0d got=%b/%0d exp=1/%0d", k, d3_drop_pulse, d3_drop_count, k);
         end
         total++;
         if (d3_out_valid !== 3'b010 || d3_out_data[31:16] !== y) begin
            bad++; $display("FAIL oor_slots #%0d got=%b/%h exp=010/%h", k, d3_out_valid, d3_out_data[31:16], y);
         end
      end
      d3_valid = 1'b0;
      tick();
      total++;
      if (d3_drop_pulse !== 1'b0 || d3_drop_count !== 16'd3) begin
         bad++; $display("FAIL oor_after got=%b/%0d exp=0/3", d3_drop_pulse, d3_drop_count);
      end
      d3_out_ready = 3'b111; d3_data = 16'hC0DE; d3_sel = 2'd3; d3_bcast = 1'b1; d3_valid = 1'b1;
      tick();
      d3_valid = 1'b0; d3_bcast = 1'b0; d3_out_ready = 3'b000;
      total++;
      if (d3_out_valid !== 3'b111 || d3_out_data !== {3{16'hC0DE}} || d3_drop_pulse !== 1'b0) begin
         bad++; $display("FAIL oor_bcast got=%b/%h/%b exp=111/c0dec0dec0de/0", d3_out_valid, d3_out_data, d3_drop_pulse);
      end
      d3_out_ready = 3'b111;
      tick();
   endtask

   task automatic test_streaming();
      logic [N-1:0] exp_v;
      int seen;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         drive(W'($urandom), 2'($urandom_range(0, 3)), 1'b0, 1'b1, 4'b1111);
         #1;
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready #%0d got=%b exp=1", k, in_ready); end
         tick();
         exp_v = model_valid();
         seen += $countones(out_valid);
         total++;
         if (out_valid !== exp_v) begin bad++; $display("FAIL stream_valid #%0d got=%b exp=%b", k, out_valid, exp_v); end
         for (int i = 0; i < N; i++) begin
            if (exp_v[i]) begin
               total++;
               if (out_data[i*W +: W] !== exp_q[i][0]) begin
                  bad++; $display("FAIL stream_data #%0d ch%0d got=%h exp=%h", k, i, out_data[i*W +: W], exp_q[i][0]);
               end
            end
         end
      end
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
      tick();
      seen += $countones(out_valid);
      total++;
      if (seen !== 100) begin bad++; $display("FAIL stream_count got=%0d exp=100", seen); end
   endtask

   task automatic test_random_backpressure();
      logic [N-1:0] exp_v;
      logic         exp_r;
      for (int k = 0; k < 300; k++) begin
         drive(W'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), 4'($urandom));
         exp_r = model_ready(in_sel, in_bcast, out_ready);
         #1;
         total++;
         if (in_ready !== exp_r) begin bad++; $display("FAIL rnd_ready #%0d got=%b exp=%b", k, in_ready, exp_r); end
         tick();
         exp_v = model_valid();
         total++;
         if (out_valid !== exp_v) begin bad++; $display("FAIL rnd_valid #%0d got=%b exp=%b", k, out_valid, exp_v); end
         for (int i = 0; i < N; i++) begin
            if (exp_v[i]) begin
               total++;
               if (out_data[i*W +: W] !== exp_q[i][0]) begin
                  bad++; $display("FAIL rnd_data #%0d ch%0d got=%h exp=%h", k, i, out_data[i*W +: W], exp_q[i][0]);
               end
            end
         end
      end
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
      tick();
      total++;
      if (out_valid !== 4'b0000) begin bad++; $display("FAIL rnd_drain got=%b exp=0000", out_valid); end
   endtask

   initial begin
      reset = 1'b1;
      drive(16'h0, 2'd0, 1'b0, 1'b0, 4'b0000);
      d3_data = '0; d3_sel = '0; d3_bcast = 1'b0; d3_valid = 1'b0; d3_out_ready = 3'b111;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_routing();
      test_backpressure();
      test_broadcast();
      test_out_of_range();
      test_streaming();
      test_random_backpressure();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
